// File: rtl/axi4_arbiter_2to1_if.sv
// AXI4 bundle shared by the arbiter and its neighbours.
// Parameters: N = data bus width in bytes, I = ID width.
// Modport M is the master side of a link, modport S the slave side.
// Channels: AW (ID/ADDR/LEN/SIZE/BURST), W (DATA/STRB/LAST), B (ID/RESP),
// AR (ID/ADDR/LEN/SIZE/BURST), R (ID/DATA/RESP/LAST), each with VALID/READY.
interface AXI4 #(
  parameter int N = 4,
  parameter int I = 4
);
  logic [I-1:0]   AWID;
  logic [31:0]    AWADDR;
  logic [7:0]     AWLEN;
  logic [2:0]     AWSIZE;
  logic [1:0]     AWBURST;
  logic           AWVALID, AWREADY;
  logic [8*N-1:0] WDATA;
  logic [N-1:0]   WSTRB;
  logic           WLAST, WVALID, WREADY;
  logic [I-1:0]   BID;
  logic [1:0]     BRESP;
  logic           BVALID, BREADY;
  logic [I-1:0]   ARID;
  logic [31:0]    ARADDR;
  logic [7:0]     ARLEN;
  logic [2:0]     ARSIZE;
  logic [1:0]     ARBURST;
  logic           ARVALID, ARREADY;
  logic [I-1:0]   RID;
  logic [8*N-1:0] RDATA;
  logic [1:0]     RRESP;
  logic           RLAST, RVALID, RREADY;

  modport M (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport S (
    input AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter. Write (AW/W/B) and read (AR/R)
// paths are arbitrated independently, each allowing one burst in flight.
// Ties go to the port that was not served last (round robin).
// Ports:
//   ACLK    - clock, rising edge
//   ARESETn - synchronous active-low reset
//   s0, s1  - upstream slave ports (ID width I)
//   m       - downstream master port (ID width I+1, MSB = granted port)
module axi4_arbiter_2to1 #(
  parameter int N = 4,
  parameter int I = 4
) (
  input logic ACLK,
  input logic ARESETn,
  AXI4.S      s0,
  AXI4.S      s1,
  AXI4.M      m
);
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_t;

  wstate_t wst, wst_nxt;
  rstate_t rst_st, rst_nxt;
  logic    wgnt, wptr, rgnt, rptr;

  // Returns the port to grant; wptr/rptr hold the port served last.
  function automatic logic pick(input logic r0, input logic r1, input logic last);
    return (r0 && r1) ? ~last : r1;
  endfunction

  // Upstream fields of the granted port.
  logic [I-1:0]   g_awid, g_arid;
  logic [31:0]    g_awaddr, g_araddr;
  logic [7:0]     g_awlen, g_arlen;
  logic [2:0]     g_awsize, g_arsize;
  logic [1:0]     g_awburst, g_arburst;
  logic           g_awvalid, g_arvalid, g_wlast, g_wvalid, g_bready, g_rready;
  logic [8*N-1:0] g_wdata;
  logic [N-1:0]   g_wstrb;

  assign g_awid    = wgnt ? s1.AWID    : s0.AWID;
  assign g_awaddr  = wgnt ? s1.AWADDR  : s0.AWADDR;
  assign g_awlen   = wgnt ? s1.AWLEN   : s0.AWLEN;
  assign g_awsize  = wgnt ? s1.AWSIZE  : s0.AWSIZE;
  assign g_awburst = wgnt ? s1.AWBURST : s0.AWBURST;
  assign g_awvalid = wgnt ? s1.AWVALID : s0.AWVALID;
  assign g_wdata   = wgnt ? s1.WDATA   : s0.WDATA;
  assign g_wstrb   = wgnt ? s1.WSTRB   : s0.WSTRB;
  assign g_wlast   = wgnt ? s1.WLAST   : s0.WLAST;
  assign g_wvalid  = wgnt ? s1.WVALID  : s0.WVALID;
  assign g_bready  = wgnt ? s1.BREADY  : s0.BREADY;
  assign g_arid    = rgnt ? s1.ARID    : s0.ARID;
  assign g_araddr  = rgnt ? s1.ARADDR  : s0.ARADDR;
  assign g_arlen   = rgnt ? s1.ARLEN   : s0.ARLEN;
  assign g_arsize  = rgnt ? s1.ARSIZE  : s0.ARSIZE;
  assign g_arburst = rgnt ? s1.ARBURST : s0.ARBURST;
  assign g_arvalid = rgnt ? s1.ARVALID : s0.ARVALID;
  assign g_rready  = rgnt ? s1.RREADY  : s0.RREADY;

  // The extra ID bit coming back from the slave is ignored; routing uses the
  // latched grant.
  logic unused_id_msb;
  assign unused_id_msb = m.BID[I] ^ m.RID[I];

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wst    <= W_IDLE;
      wgnt   <= 1'b0;
      wptr   <= 1'b1;
      rst_st <= R_IDLE;
      rgnt   <= 1'b0;
      rptr   <= 1'b1;
    end else begin
      wst    <= wst_nxt;
      rst_st <= rst_nxt;
      if (wst == W_IDLE && (s0.AWVALID || s1.AWVALID))
        wgnt <= pick(s0.AWVALID, s1.AWVALID, wptr);
      if (wst == W_RESP && m.BVALID && m.BREADY)
        wptr <= wgnt;
      if (rst_st == R_IDLE && (s0.ARVALID || s1.ARVALID))
        rgnt <= pick(s0.ARVALID, s1.ARVALID, rptr);
      if (rst_st == R_DATA && m.RVALID && m.RREADY && m.RLAST)
        rptr <= rgnt;
    end
  end

  // Write path: next state and channel steering.
  always_comb begin
    wst_nxt    = wst;
    m.AWID     = '0;
    m.AWADDR   = '0;
    m.AWLEN    = '0;
    m.AWSIZE   = '0;
    m.AWBURST  = '0;
    m.AWVALID  = 1'b0;
    m.WDATA    = '0;
    m.WSTRB    = '0;
    m.WLAST    = 1'b0;
    m.WVALID   = 1'b0;
    m.BREADY   = 1'b0;
    s0.AWREADY = 1'b0;
    s0.WREADY  = 1'b0;
    s0.BVALID  = 1'b0;
    s0.BID     = '0;
    s0.BRESP   = '0;
    s1.AWREADY = 1'b0;
    s1.WREADY  = 1'b0;
    s1.BVALID  = 1'b0;
    s1.BID     = '0;
    s1.BRESP   = '0;
    case (wst)
      W_IDLE: if (s0.AWVALID || s1.AWVALID) wst_nxt = W_ADDR;
      W_ADDR: begin
        m.AWID    = {wgnt, g_awid};
        m.AWADDR  = g_awaddr;
        m.AWLEN   = g_awlen;
        m.AWSIZE  = g_awsize;
        m.AWBURST = g_awburst;
        m.AWVALID = g_awvalid;
        if (wgnt) s1.AWREADY = m.AWREADY;
        else      s0.AWREADY = m.AWREADY;
        if (g_awvalid && m.AWREADY) wst_nxt = W_DATA;
      end
      W_DATA: begin
        m.WDATA  = g_wdata;
        m.WSTRB  = g_wstrb;
        m.WLAST  = g_wlast;
        m.WVALID = g_wvalid;
        if (wgnt) s1.WREADY = m.WREADY;
        else      s0.WREADY = m.WREADY;
        if (g_wvalid && m.WREADY && g_wlast) wst_nxt = W_RESP;
      end
      W_RESP: begin
        m.BREADY = g_bready;
        if (wgnt) begin
          s1.BVALID = m.BVALID;
          s1.BID    = m.BID[I-1:0];
          s1.BRESP  = m.BRESP;
        end else begin
          s0.BVALID = m.BVALID;
          s0.BID    = m.BID[I-1:0];
          s0.BRESP  = m.BRESP;
        end
        if (m.BVALID && g_bready) wst_nxt = W_IDLE;
      end
      default: wst_nxt = W_IDLE;
    endcase
  end

  // Read path: next state and channel steering.
  always_comb begin
    rst_nxt    = rst_st;
    m.ARID     = '0;
    m.ARADDR   = '0;
    m.ARLEN    = '0;
    m.ARSIZE   = '0;
    m.ARBURST  = '0;
    m.ARVALID  = 1'b0;
    m.RREADY   = 1'b0;
    s0.ARREADY = 1'b0;
    s0.RVALID  = 1'b0;
    s0.RID     = '0;
    s0.RDATA   = '0;
    s0.RRESP   = '0;
    s0.RLAST   = 1'b0;
    s1.ARREADY = 1'b0;
    s1.RVALID  = 1'b0;
    s1.RID     = '0;
    s1.RDATA   = '0;
    s1.RRESP   = '0;
    s1.RLAST   = 1'b0;
    case (rst_st)
      R_IDLE: if (s0.ARVALID || s1.ARVALID) rst_nxt = R_ADDR;
      R_ADDR: begin
        m.ARID    = {rgnt, g_arid};
        m.ARADDR  = g_araddr;
        m.ARLEN   = g_arlen;
        m.ARSIZE  = g_arsize;
        m.ARBURST = g_arburst;
        m.ARVALID = g_arvalid;
        if (rgnt) s1.ARREADY = m.ARREADY;
        else      s0.ARREADY = m.ARREADY;
        if (g_arvalid && m.ARREADY) rst_nxt = R_DATA;
      end
      R_DATA: begin
        m.RREADY = g_rready;
        if (rgnt) begin
          s1.RVALID = m.RVALID;
          s1.RID    = m.RID[I-1:0];
          s1.RDATA  = m.RDATA;
          s1.RRESP  = m.RRESP;
          s1.RLAST  = m.RLAST;
        end else begin
          s0.RVALID = m.RVALID;
          s0.RID    = m.RID[I-1:0];
          s0.RDATA  = m.RDATA;
          s0.RRESP  = m.RRESP;
          s0.RLAST  = m.RLAST;
        end
        if (m.RVALID && g_rready && m.RLAST) rst_nxt = R_IDLE;
      end
      default: rst_nxt = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4_arbiter_2to1.sv
module tb_axi4_arbiter_2to1;
  logic clk = 1'b0;
  logic ARESETn;
  always #5 clk = ~clk;

  AXI4 #(.N(4), .I(4)) s0_if ();
  AXI4 #(.N(4), .I(4)) s1_if ();
  AXI4 #(.N(4), .I(5)) m_if ();

  axi4_arbiter_2to1 #(.N(4), .I(4)) dut (
    .ACLK(clk), .ARESETn(ARESETn), .s0(s0_if), .s1(s1_if), .m(m_if)
  );

  // Upstream master drive/observe arrays, index = port.
  logic [1:0]  awvalid, wvalid, wlast, bready, arvalid, rready;
  logic [1:0]  awready, wready, bvalid, arready, rvalid, rlast;
  logic [3:0]  awid [2], arid [2], bid [2], rid [2], wstrb [2];
  logic [31:0] awaddr [2], araddr [2], wdata [2], rdata [2];
  logic [7:0]  awlen [2], arlen [2];
  logic [1:0]  bresp [2], rresp [2];

  assign s0_if.AWID = awid[0];       assign s1_if.AWID = awid[1];
  assign s0_if.AWADDR = awaddr[0];   assign s1_if.AWADDR = awaddr[1];
  assign s0_if.AWLEN = awlen[0];     assign s1_if.AWLEN = awlen[1];
  assign s0_if.AWSIZE = 3'd2;        assign s1_if.AWSIZE = 3'd1;
  assign s0_if.AWBURST = 2'b01;      assign s1_if.AWBURST = 2'b10;
  assign s0_if.AWVALID = awvalid[0]; assign s1_if.AWVALID = awvalid[1];
  assign s0_if.WDATA = wdata[0];     assign s1_if.WDATA = wdata[1];
  assign s0_if.WSTRB = wstrb[0];     assign s1_if.WSTRB = wstrb[1];
  assign s0_if.WLAST = wlast[0];     assign s1_if.WLAST = wlast[1];
  assign s0_if.WVALID = wvalid[0];   assign s1_if.WVALID = wvalid[1];
  assign s0_if.BREADY = bready[0];   assign s1_if.BREADY = bready[1];
  assign s0_if.ARID = arid[0];       assign s1_if.ARID = arid[1];
  assign s0_if.ARADDR = araddr[0];   assign s1_if.ARADDR = araddr[1];
  assign s0_if.ARLEN = arlen[0];     assign s1_if.ARLEN = arlen[1];
  assign s0_if.ARSIZE = 3'd2;        assign s1_if.ARSIZE = 3'd1;
  assign s0_if.ARBURST = 2'b01;      assign s1_if.ARBURST = 2'b10;
  assign s0_if.ARVALID = arvalid[0]; assign s1_if.ARVALID = arvalid[1];
  assign s0_if.RREADY = rready[0];   assign s1_if.RREADY = rready[1];

  assign awready = {s1_if.AWREADY, s0_if.AWREADY};
  assign wready  = {s1_if.WREADY,  s0_if.WREADY};
  assign bvalid  = {s1_if.BVALID,  s0_if.BVALID};
  assign arready = {s1_if.ARREADY, s0_if.ARREADY};
  assign rvalid  = {s1_if.RVALID,  s0_if.RVALID};
  assign rlast   = {s1_if.RLAST,   s0_if.RLAST};
  assign bid[0] = s0_if.BID;         assign bid[1] = s1_if.BID;
  assign bresp[0] = s0_if.BRESP;     assign bresp[1] = s1_if.BRESP;
  assign rid[0] = s0_if.RID;         assign rid[1] = s1_if.RID;
  assign rdata[0] = s0_if.RDATA;     assign rdata[1] = s1_if.RDATA;
  assign rresp[0] = s0_if.RRESP;     assign rresp[1] = s1_if.RRESP;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Full write burst from port p; slave side holds B for bstall cycles with
  // the master not ready. Called and returns just after a falling edge.
  task automatic do_write(input bit p, input logic [3:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [1:0] resp, input int bstall,
                          input logic [4:0] exp_mid);
    logic [31:0] d;
    awid[p] = id; awaddr[p] = addr; awlen[p] = len; awvalid[p] = 1'b1;
    m_if.AWREADY = 1'b0; m_if.WREADY = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (m_if.AWVALID) break;
      @(negedge clk);
    end
    chk("aw_grant", m_if.AWVALID, 1);
    chk("aw_id", m_if.AWID, exp_mid);
    chk("aw_addr_len", {m_if.AWADDR, m_if.AWLEN}, {addr, len});
    chk("aw_size_burst", {m_if.AWSIZE, m_if.AWBURST}, p ? 5'b001_10 : 5'b010_01);
    chk("w_hold", {wready, m_if.WVALID}, 0);
    m_if.AWREADY = 1'b1; #1;
    chk("aw_ready", awready, 2'b01 << p);
    @(negedge clk);
    awvalid[p] = 1'b0; m_if.AWREADY = 1'b0;
    for (int b = 0; b <= int'(len); b++) begin
      d = {addr[15:0], 8'(b), 4'h0, id};
      wdata[p] = d; wstrb[p] = p ? 4'h3 : 4'hF; wlast[p] = (b == int'(len)); wvalid[p] = 1'b1;
      #1;
      chk("w_data", {m_if.WDATA, m_if.WSTRB}, {d, p ? 4'h3 : 4'hF});
      chk("w_ctl", {m_if.WVALID, m_if.WLAST, wready}, {1'b1, 1'(b == int'(len)), 2'b01 << p});
      @(negedge clk);
    end
    wvalid[p] = 1'b0; wlast[p] = 1'b0;
    m_if.BID = exp_mid; m_if.BRESP = resp; m_if.BVALID = 1'b1; bready[p] = 1'b0;
    for (int s = 0; s < bstall; s++) begin
      #1;
      chk("b_stall", {m_if.BREADY, m_if.AWVALID, bvalid}, {2'b00, 2'b01 << p});
      @(negedge clk);
    end
    bready[p] = 1'b1; #1;
    chk("b_route", {bvalid, bid[p], bresp[p]}, {2'b01 << p, id, resp});
    chk("b_other", {bid[~p], bresp[~p]}, 0);
    chk("b_ready", m_if.BREADY, 1);
    @(negedge clk);
    m_if.BVALID = 1'b0; m_if.BID = '0; m_if.BRESP = '0; bready[p] = 1'b0;
    #1;
    chk("b_done", {m_if.BREADY, bvalid}, 0);
  endtask

  task automatic do_read(input bit p, input logic [3:0] id, input logic [31:0] addr,
                         input logic [7:0] len, input logic [1:0] resp,
                         input logic [4:0] exp_mid);
    logic [31:0] d;
    arid[p] = id; araddr[p] = addr; arlen[p] = len; arvalid[p] = 1'b1;
    m_if.ARREADY = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (m_if.ARVALID) break;
      @(negedge clk);
    end
    chk("ar_grant", m_if.ARVALID, 1);
    chk("ar_id", m_if.ARID, exp_mid);
    chk("ar_addr_len", {m_if.ARADDR, m_if.ARLEN}, {addr, len});
    chk("ar_size_burst", {m_if.ARSIZE, m_if.ARBURST}, p ? 5'b001_10 : 5'b010_01);
    m_if.ARREADY = 1'b1; #1;
    chk("ar_ready", arready, 2'b01 << p);
    @(negedge clk);
    arvalid[p] = 1'b0; m_if.ARREADY = 1'b0; rready[p] = 1'b1;
    for (int b = 0; b <= int'(len); b++) begin
      d = {8'(b), addr[15:0], 4'h5, id};
      m_if.RVALID = 1'b1; m_if.RID = exp_mid; m_if.RDATA = d; m_if.RRESP = resp;
      m_if.RLAST = (b == int'(len));
      #1;
      chk("r_route", {rvalid, rid[p], rresp[p], rlast}, {2'b01 << p, id, resp, 1'(b == int'(len)) ? 2'b01 << p : 2'b00});
      chk("r_data", rdata[p], d);
      chk("r_other", {rdata[~p], rid[~p], rresp[~p]}, 0);
      chk("r_ready", m_if.RREADY, 1);
      @(negedge clk);
    end
    m_if.RVALID = 1'b0; m_if.RLAST = 1'b0; m_if.RID = '0; m_if.RDATA = '0; m_if.RRESP = '0;
    rready[p] = 1'b0;
    #1;
    chk("r_done", {m_if.RREADY, rvalid}, 0);
  endtask

  task automatic clear_inputs();
    awvalid = '0; wvalid = '0; wlast = '0; bready = '0; arvalid = '0; rready = '0;
    for (int q = 0; q < 2; q++) begin
      awid[q] = '0; awaddr[q] = '0; awlen[q] = '0; wdata[q] = '0; wstrb[q] = '0;
      arid[q] = '0; araddr[q] = '0; arlen[q] = '0;
    end
    m_if.AWREADY = 1'b0; m_if.WREADY = 1'b0; m_if.BVALID = 1'b0; m_if.BID = '0; m_if.BRESP = '0;
    m_if.ARREADY = 1'b0; m_if.RVALID = 1'b0; m_if.RID = '0; m_if.RDATA = '0;
    m_if.RRESP = '0; m_if.RLAST = 1'b0;
  endtask

  task automatic chk_quiet(input string nm);
    chk({nm, "_hs"}, {awready, wready, arready, bvalid, rvalid, m_if.AWVALID, m_if.WVALID,
                      m_if.ARVALID, m_if.BREADY, m_if.RREADY}, 0);
    chk({nm, "_mpay"}, {m_if.AWADDR, m_if.AWID, m_if.ARID, m_if.AWLEN}, 0);
    chk({nm, "_rdata"}, {rdata[0], rdata[1]}, 0);
  endtask

  typedef struct {
    bit          wr;
    bit          p;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  resp;
    logic [4:0]  exp_mid;
  } vec_t;
  vec_t tbl [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t0;
    tbl[0] = '{1'b1, 1'b0, 4'h3, 32'h0000_0100, 8'd3, 2'd0, 5'h03};
    tbl[1] = '{1'b1, 1'b1, 4'hA, 32'h0000_2000, 8'd0, 2'd2, 5'h1A};
    tbl[2] = '{1'b0, 1'b1, 4'h5, 32'h0000_0300, 8'd0, 2'd0, 5'h15};
    tbl[3] = '{1'b0, 1'b0, 4'hF, 32'h0000_0044, 8'd2, 2'd1, 5'h0F};
    tbl[4] = '{1'b1, 1'b1, 4'h0, 32'h0001_0010, 8'd1, 2'd3, 5'h10};

    // Reset with traffic pending on every side: nothing may leak through.
    clear_inputs();
    ARESETn = 1'b0;
    repeat (2) @(negedge clk);
    awvalid = 2'b01; arvalid = 2'b10; wvalid = 2'b11; bready = 2'b11; rready = 2'b11;
    m_if.AWREADY = 1'b1; m_if.WREADY = 1'b1; m_if.ARREADY = 1'b1;
    m_if.BVALID = 1'b1; m_if.RVALID = 1'b1; m_if.RDATA = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    chk_quiet("reset");
    clear_inputs();
    ARESETn = 1'b1;
    @(negedge clk); #1;
    chk_quiet("post_reset");

    for (int v = 0; v < 5; v++) begin
      if (tbl[v].wr) do_write(tbl[v].p, tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].resp, 0, tbl[v].exp_mid);
      else           do_read(tbl[v].p, tbl[v].id, tbl[v].addr, tbl[v].len, tbl[v].resp, tbl[v].exp_mid);
    end

    // Tie: s0 wins (s1 was served last), then s1, then tie again -> s0.
    awid[1] = 4'h8; awaddr[1] = 32'h800; awlen[1] = 8'd0; awvalid[1] = 1'b1;
    do_write(1'b0, 4'h4, 32'h400, 8'd0, 2'd0, 0, 5'h04);
    do_write(1'b1, 4'h8, 32'h800, 8'd0, 2'd1, 0, 5'h18);
    awid[1] = 4'h8; awaddr[1] = 32'h800; awlen[1] = 8'd0; awvalid[1] = 1'b1;
    do_write(1'b0, 4'h4, 32'h440, 8'd1, 2'd0, 0, 5'h04);
    do_write(1'b1, 4'h8, 32'h800, 8'd0, 2'd0, 0, 5'h18);

    // Write data offered before its address must be held off.
    m_if.WREADY = 1'b1;
    wvalid[1] = 1'b1; wdata[1] = 32'hDEAD_BEEF; wstrb[1] = 4'h3; wlast[1] = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      chk("w_early", {wready, m_if.WVALID}, 0);
    end
    do_write(1'b1, 4'h6, 32'h600, 8'd1, 2'd0, 0, 5'h16);

    // B stalled for 5 cycles with s1 waiting: no new AW until B completes.
    awid[1] = 4'h7; awaddr[1] = 32'h700; awlen[1] = 8'd0; awvalid[1] = 1'b1;
    do_write(1'b0, 4'h1, 32'h900, 8'd0, 2'd0, 5, 5'h01);
    do_write(1'b1, 4'h7, 32'h700, 8'd0, 2'd2, 0, 5'h17);

    // Concurrent 8-beat write on s0 and single-beat read on s1.
    fork
      do_write(1'b0, 4'h2, 32'hA00, 8'd7, 2'd0, 0, 5'h02);
      begin
        t0 = cyc;
        do_read(1'b1, 4'h5, 32'hB00, 8'd0, 2'd0, 5'h15);
        chk("r_concurrent_latency", (cyc - t0) <= 4, 1);
      end
    join

    // Reset during beat 2 of an 8-beat s0 read.
    arid[0] = 4'h2; araddr[0] = 32'hC00; arlen[0] = 8'd7; arvalid[0] = 1'b1;
    m_if.ARREADY = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      if (m_if.ARVALID) break;
      @(negedge clk);
    end
    chk("rst_ar_grant", m_if.ARVALID, 1);
    m_if.ARREADY = 1'b1;
    @(negedge clk);
    arvalid[0] = 1'b0; m_if.ARREADY = 1'b0; rready[0] = 1'b1;
    for (int b = 0; b < 3; b++) begin
      m_if.RVALID = 1'b1; m_if.RID = 5'h02; m_if.RDATA = 32'h100 + b; m_if.RLAST = 1'b0;
      #1;
      chk("rst_beat", {rvalid, rdata[0]}, {2'b01, 32'h100 + b});
      if (b == 2) ARESETn = 1'b0;
      @(negedge clk);
    end
    #1;
    chk_quiet("rst_mid");
    chk("rst_mid_r", {rvalid, rlast}, 0);
    m_if.RVALID = 1'b0; m_if.RID = '0; m_if.RDATA = '0; rready[0] = 1'b0;
    ARESETn = 1'b1;
    @(negedge clk); #1;
    chk_quiet("rst_release");
    do_read(1'b1, 4'h9, 32'hD00, 8'd1, 2'd0, 5'h19);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
